instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter INST_SIZE, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_addr  output  ADDR_SIZE  word address to instruction memory.
REQ-007 SHALL have port imem_instr  input  INST_SIZE  combinational read data for imem_addr.
REQ-008 SHALL have port if_valid  output  1  fetched instruction available to decode.
REQ-009 SHALL have port if_ready  input  1  decode accepts the instruction this cycle.
REQ-010 SHALL have port if_instr  output  INST_SIZE  fetched instruction.
REQ-011 SHALL have port if_pc  output  32  byte address of if_instr.
REQ-012 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-013 SHALL have port redirect_pc  input  32  byte target address.
REQ-014 SHALL have port halt_req  input  1  level; suspend new fetches.
REQ-015 SHALL have port misalign_err  output  1  sticky misaligned-redirect fault.
REQ-016 SHALL have port fetch_count  output  32  number of completed if_valid&&if_ready handshakes.

Function
REQ-017 SHALL hold a 32-bit fetch_pc register; imem_addr = fetch_pc[ADDR_SIZE+1:2], combinational.
REQ-018 SHALL implement states FETCH, HALTED, FAULT; FETCH after reset.
REQ-019 In FETCH, when output slot free (if_valid=0 or if_ready=1) and no redirect: capture {fetch_pc, imem_instr} into {if_pc, if_instr}, set if_valid=1, fetch_pc += 4 (one-cycle latency, one instruction per cycle sustained).
REQ-020 When if_valid=1 and if_ready=0: if_valid, if_instr, if_pc, fetch_pc SHALL hold stable.
REQ-021 redirect_valid SHALL have highest priority: next cycle if_valid=0 (pending output flushed, even if if_ready=1 same cycle, which still counts as a handshake), fetch_pc=redirect_pc, no capture that cycle.
REQ-022 redirect_pc[1:0]!=0 SHALL move to FAULT: misalign_err=1, if_valid=0, fetch_pc unchanged; FAULT exits only by reset.
REQ-023 halt_req=1 in FETCH SHALL move to HALTED next cycle with no new capture; valid output remains until accepted.
REQ-024 In HALTED, halt_req=0 SHALL return to FETCH; redirects in HALTED update fetch_pc (aligned) or enter FAULT (misaligned).
REQ-025 fetch_pc SHALL wrap modulo 2^32; imem_addr wraps modulo 2^ADDR_SIZE words.
REQ-026 fetch_count SHALL increment by 1 per handshake, wrapping modulo 2^32.

Reset
REQ-027 rst_n=0 SHALL immediately set fetch_pc=RESET_PC, state=FETCH, if_valid=0, if_instr=0, if_pc=0, misalign_err=0, fetch_count=0, regardless of in-flight activity.
REQ-028 First capture SHALL occur on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 State enum (FETCH, HALTED, FAULT) and PC_STEP=4 SHALL reside in shared package riscv_pkg.
REQ-030 SHALL be a single module; no sub-modules; no memory inside.

Verification
REQ-031 Reset, if_ready=1, memory word n = n -> if_pc 0x0,0x4,0x8 with if_instr 0,1,2 on consecutive cycles; fetch_count 3.
REQ-032 Word 8 = 32'h00208433, redirect_pc=0x20 -> next cycle if_valid=0, following cycle if_pc=0x20, if_instr=32'h00208433.
REQ-033 if_ready=0 for 3 cycles with if_valid=1 -> outputs and imem_addr stable; release -> next pc +4 captured.
REQ-034 redirect_pc=0x22 -> misalign_err=1, if_valid=0 until rst_n pulse, then fetch restarts at RESET_PC.
REQ-035 redirect_pc=0x3FC, ADDR_SIZE=8 -> imem_addr 0xFF then 0x00 with if_pc 0x400.
REQ-036 halt_req=1 two cycles, then rst_n low mid-stream -> no captures while halted; all outputs zero asynchronously on reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: FSM state encoding and PC increment.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction fetch targets must be word aligned.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: a single output slot fed from a combinational
// instruction memory, with redirect, halt and sticky misalignment fault.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int          ADDR_SIZE = 8,
  parameter int          INST_SIZE = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic [INST_SIZE-1:0] imem_instr,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [INST_SIZE-1:0] if_instr,
  output logic [31:0]          if_pc,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 halt_req,
  output logic                 misalign_err,
  output logic [31:0]          fetch_count
);

  fetch_state_e         state, state_nxt;
  logic [31:0]          fetch_pc, fetch_pc_nxt;
  logic                 vld_nxt;
  logic [INST_SIZE-1:0] instr_nxt;
  logic [31:0]          pc_out_nxt;
  logic                 err_nxt;
  logic                 accept;

  // Word address is the byte PC with the byte offset dropped; upper bits
  // simply fall off, so the memory index wraps on its own.
  assign imem_addr = fetch_pc[ADDR_SIZE+1:2];
  assign accept    = if_valid && if_ready;

  // Next state and datapath: redirect beats halt beats capture.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    vld_nxt      = if_valid && !if_ready;
    instr_nxt    = if_instr;
    pc_out_nxt   = if_pc;
    err_nxt      = misalign_err;
    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          // Flush the slot; the consumer may still take it this cycle.
          vld_nxt = 1'b0;
          if (pc_misaligned(redirect_pc)) begin
            state_nxt = FAULT;
            err_nxt   = 1'b1;
          end else begin
            fetch_pc_nxt = redirect_pc;
          end
        end else if (halt_req) begin
          state_nxt = HALTED;
        end else if (!if_valid || if_ready) begin
          vld_nxt      = 1'b1;
          instr_nxt    = imem_instr;
          pc_out_nxt   = fetch_pc;
          fetch_pc_nxt = fetch_pc + PC_STEP;
        end
      end
      HALTED: begin
        if (redirect_valid && pc_misaligned(redirect_pc)) begin
          vld_nxt   = 1'b0;
          state_nxt = FAULT;
          err_nxt   = 1'b1;
        end else begin
          if (redirect_valid) begin
            vld_nxt      = 1'b0;
            fetch_pc_nxt = redirect_pc;
          end
          if (!halt_req) state_nxt = FETCH;
        end
      end
      FAULT: begin
        vld_nxt = 1'b0;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // State, fetch PC, output slot and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      fetch_pc     <= RESET_PC;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_nxt;
      fetch_pc     <= fetch_pc_nxt;
      if_valid     <= vld_nxt;
      if_instr     <= instr_nxt;
      if_pc        <= pc_out_nxt;
      misalign_err <= err_nxt;
      if (accept) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
